// File: rtl/acc_pkg.sv
// Shared types and constants for the accumulator read-side blocks.
package acc_pkg;

  localparam int unsigned ACC_DATA_W = 32;

  typedef enum logic [0:0] {IDLE, STREAM} acc_drain_state_t;

  typedef logic [ACC_DATA_W-1:0] acc_word_t;

endpackage

// File: rtl/acc_frame_buf.sv
// One snapshot bank: whole-frame write, indexed word read, per-word presentable mask.
// ACC_DRAIN_SKIP_ZERO_EN: zero words are reported as not presentable.
module acc_frame_buf import acc_pkg::*; #(
  parameter int unsigned DATA_W    = ACC_DATA_W,
  parameter int unsigned NUM_WORDS = 2,
  parameter int unsigned IDX_W     = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [NUM_WORDS*DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]            rd_idx,
  output logic [DATA_W-1:0]           rd_data,
  output logic [NUM_WORDS-1:0]        present
);

  logic [NUM_WORDS*DATA_W-1:0] mem_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q <= '0;
    end else if (wr_en) begin
      mem_q <= wr_data;
    end
  end

  assign rd_data = mem_q[int'(rd_idx)*DATA_W +: DATA_W];

  always_comb begin
    present = '0;
    for (int k = 0; k < int'(NUM_WORDS); k++) begin
`ifdef ACC_DRAIN_SKIP_ZERO_EN
      present[k] = |mem_q[k*DATA_W +: DATA_W];
`else
      present[k] = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/acc_drain.sv
// Ping-pong snapshot drain: captures a whole frame in one cycle, streams it one word per beat.
// ACC_DRAIN_SKIP_ZERO_EN: zero words are skipped and all-zero frames produce no beats.
module acc_drain import acc_pkg::*; #(
  parameter int unsigned DATA_W    = ACC_DATA_W,
  parameter int unsigned NUM_WORDS = 2,
  parameter int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load,
  input  logic [NUM_WORDS*DATA_W-1:0] load_data,
  output logic                        load_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [IDX_W-1:0]            out_index,
  output logic                        out_last,
  output logic                        frame_done,
  output logic                        busy,
  output logic                        drop
);

  acc_drain_state_t state_q, state_d;
  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             frame_done_q, frame_done_d;
  logic             drop_q, drop_d;

  logic [1:0]           wr_en;
  logic [DATA_W-1:0]    bank_rd [2];
  logic [NUM_WORDS-1:0] bank_present [2];
  logic [NUM_WORDS-1:0] load_mask;
  logic [NUM_WORDS-1:0] cur_mask;
  logic                 beat, last, done_beat, accept, load_zero, store;

  // Lowest presentable position at or above start; 0 when there is none.
  function automatic logic [IDX_W-1:0] first_at(input logic [NUM_WORDS-1:0] m, input int start);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = int'(NUM_WORDS) - 1; i >= 0; i--) begin
      if (i >= start && m[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  function automatic logic any_at(input logic [NUM_WORDS-1:0] m, input int start);
    logic r;
    r = 1'b0;
    for (int i = 0; i < int'(NUM_WORDS); i++) begin
      if (i >= start && m[i]) r = 1'b1;
    end
    return r;
  endfunction

  for (genvar b = 0; b < 2; b++) begin : g_bank
    acc_frame_buf #(
      .DATA_W    (DATA_W),
      .NUM_WORDS (NUM_WORDS),
      .IDX_W     (IDX_W)
    ) u_bank (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en[b]),
      .wr_data (load_data),
      .rd_idx  (idx_q),
      .rd_data (bank_rd[b]),
      .present (bank_present[b])
    );
  end

  always_comb begin
    load_mask = '0;
    for (int k = 0; k < int'(NUM_WORDS); k++) begin
`ifdef ACC_DRAIN_SKIP_ZERO_EN
      load_mask[k] = |load_data[k*DATA_W +: DATA_W];
`else
      load_mask[k] = 1'b1;
`endif
    end
  end

  assign load_ready = ~&full_q;
  assign busy       = |full_q;
  assign out_valid  = (state_q == STREAM);
  assign out_data   = bank_rd[rd_bank_q];
  assign out_index  = idx_q;
  assign frame_done = frame_done_q;
  assign drop       = drop_q;

  assign cur_mask  = bank_present[rd_bank_q];
  assign last      = ~any_at(cur_mask, int'(idx_q) + 1);
  assign out_last  = out_valid & last;
  assign beat      = out_valid & out_ready;
  assign done_beat = beat & last;
  assign accept    = load & load_ready;
  // An all-zero frame (only possible with skipping on) never occupies a bank.
  assign load_zero = ~|load_mask;
  assign store     = accept & ~load_zero;
  assign wr_en     = {store & wr_bank_q, store & ~wr_bank_q};

  always_comb begin
    full_d       = full_q;
    wr_bank_d    = wr_bank_q ^ store;
    rd_bank_d    = rd_bank_q ^ done_beat;
    idx_d        = idx_q;
    state_d      = state_q;
    frame_done_d = done_beat | (accept & load_zero);
    drop_d       = drop_q | (load & ~load_ready);

    if (done_beat) full_d[rd_bank_q] = 1'b0;
    if (store)     full_d[wr_bank_q] = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (store) state_d = STREAM;
      end
      STREAM: begin
        if (done_beat && !full_q[~rd_bank_q] && !store) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Next head frame may already sit in the other bank or be arriving this cycle.
    if (beat && !last) begin
      idx_d = first_at(cur_mask, int'(idx_q) + 1);
    end else if (done_beat || state_q == IDLE) begin
      if (full_q[rd_bank_d])  idx_d = first_at(bank_present[rd_bank_d], 0);
      else if (store)         idx_d = first_at(load_mask, 0);
      else                    idx_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      full_q       <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      full_q       <= full_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      idx_q        <= idx_d;
      frame_done_q <= frame_done_d;
      drop_q       <= drop_d;
    end
  end

endmodule

// File: tb/tb_acc_drain.sv
// Randomized bench for acc_drain against a frame-queue reference model.
module tb_acc_drain;

  localparam int NW = 2;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              load;
  logic [NW*DW-1:0]  load_data;
  logic              load_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [0:0]        out_index;
  logic              out_last;
  logic              frame_done;
  logic              busy;
  logic              drop;

  acc_drain dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_data  (load_data),
    .load_ready (load_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_last   (out_last),
    .frame_done (frame_done),
    .busy       (busy),
    .drop       (drop)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: queue of accepted frames, position of the current beat in the head frame.
  logic [NW*DW-1:0] fq[$];
  int               ptr;
  bit               done_m;
  bit               drop_m;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit shown(input logic [DW-1:0] w);
`ifdef ACC_DRAIN_SKIP_ZERO_EN
    return w != 0;
`else
    return w == w;
`endif
  endfunction

  function automatic int next_pos(input logic [NW*DW-1:0] f, input int start);
    for (int k = start; k < NW; k++) begin
      if (shown(f[k*DW +: DW])) return k;
    end
    return NW;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    case ($urandom_range(3))
      0:       return '0;
      1:       return DW'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  task automatic check_reset_values();
    check("rst_out_valid",  64'(out_valid),  64'(0));
    check("rst_out_data",   64'(out_data),   64'(0));
    check("rst_out_index",  64'(out_index),  64'(0));
    check("rst_out_last",   64'(out_last),   64'(0));
    check("rst_load_ready", 64'(load_ready), 64'(1));
    check("rst_frame_done", 64'(frame_done), 64'(0));
    check("rst_busy",       64'(busy),       64'(0));
    check("rst_drop",       64'(drop),       64'(0));
  endtask

  task automatic run(input int cycles, input int load_pct, input int rdy_pct);
    bit beat, space, head_new;
    int np;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      check("out_valid",  64'(out_valid),  64'(fq.size() > 0));
      check("load_ready", 64'(load_ready), 64'(fq.size() < 2));
      check("busy",       64'(busy),       64'(fq.size() > 0));
      check("frame_done", 64'(frame_done), 64'(done_m));
      check("drop",       64'(drop),       64'(drop_m));
      if (fq.size() > 0) begin
        check("out_data",  64'(out_data),  64'(fq[0][ptr*DW +: DW]));
        check("out_index", 64'(out_index), 64'(ptr));
        check("out_last",  64'(out_last),  64'(next_pos(fq[0], ptr + 1) == NW));
      end
      load      = ($urandom_range(99) < load_pct);
      load_data = {rand_word(), rand_word()};
      out_ready = ($urandom_range(99) < rdy_pct);

      @(posedge clk);
      beat     = (fq.size() > 0) && out_ready;
      space    = fq.size() < 2;
      done_m   = 0;
      head_new = 0;
      if (load && !space) drop_m = 1;
      if (beat) begin
        np = next_pos(fq[0], ptr + 1);
        if (np == NW) begin
          void'(fq.pop_front());
          done_m   = 1;
          head_new = 1;
        end else begin
          ptr = np;
        end
      end
      if (load && space) begin
        if (next_pos(load_data, 0) == NW) begin
          done_m = 1;
        end else begin
          fq.push_back(load_data);
          if (fq.size() == 1) head_new = 1;
        end
      end
      if (head_new) ptr = (fq.size() > 0) ? next_pos(fq[0], 0) : 0;
    end
  endtask

  initial begin
    reset     = 1'b0;
    load      = 1'b0;
    load_data = '0;
    out_ready = 1'b0;
    ptr       = 0;
    done_m    = 0;
    drop_m    = 0;
    #7;
    check_reset_values();
    @(negedge clk);
    reset = 1'b1;

    run(300, 50, 100);
    run(300, 60, 50);
    run(300, 80, 15);
    run(200, 30, 90);

    // Fill with downstream stalled, then reset asynchronously mid-frame.
    run(3, 100, 0);
    @(negedge clk);
    load      = 1'b0;
    out_ready = 1'b0;
    #2 reset  = 1'b0;
    #1;
    check_reset_values();
    fq.delete();
    ptr    = 0;
    done_m = 0;
    drop_m = 0;
    @(negedge clk);
    reset = 1'b1;

    run(300, 50, 70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
